seq_store_aligner: RTL and testbench
====================================

Name: seq_store_aligner

Overview:
- Sits directly downstream of the lane deshuffle stage. Consumes sequential store beats: bus-wide nibble data plus per-nibble enables, in element order, starting at byte 0 of the request.
- Realigns the stream to the destination byte offset within the bus word and converts nibble enables to byte strobes.
- Emits AXI-style W beats with last flag; one request active at a time, issued by the store control path.

Parameters:
- NrLanes, 4, number of vector lanes.
- DLEN, 64, per-lane datapath width in bits.
- LenBits, 16, width of the request byte-count field.
- BusBits, NrLanes*DLEN (derived, do not override), W data width in bits; BusBytes = BusBits/8.
- OffBits, $clog2(BusBytes) (derived), width of the byte offset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_off_i  in  OffBits  destination byte offset within first bus word.
- req_nbytes_i  in  LenBits  total bytes in request.
- seq_valid_i  in  1  input beat valid.
- seq_ready_o  out  1  input beat ready.
- seq_nb_i  in  BusBits  input data; byte i = stream byte (beat*BusBytes + i).
- seq_en_i  in  BusBits/4  per-nibble enables.
- w_valid_o  out  1  W beat valid.
- w_ready_i  in  1  W beat ready.
- w_data_o  out  BusBits  W data.
- w_strb_o  out  BusBytes  W byte strobes.
- w_last_o  out  1  last beat of request.
- done_o  out  1  single-cycle pulse when request completes.

Behaviour:
- States: IDLE, STREAM, FLUSH.
- Reset, and while in IDLE: req_ready_o=1. seq_ready_o, w_valid_o, w_last_o and done_o=0. w_data_o and w_strb_o=0. Residue data and strobes cleared.
- Reset mid-request drops all state; the next request starts clean.
- Request accept (IDLE and req_valid_i): latch off and nbytes.
  - in_beats = ceil(nbytes/BusBytes).
  - out_beats = ceil((off+nbytes)/BusBytes).
  - Counters are LenBits-OffBits+1 bits wide.
- nbytes==0: no W beats. done_o pulses the cycle after accept; state stays IDLE. req_ready_o stays 1, but a request offered on the pulse cycle is accepted only if it is nonzero.
- nbytes>0: next state is STREAM; req_ready_o=0 until completion.
- Byte strobe derivation: s[i] = seq_en_i[2i] | seq_en_i[2i+1].
- STREAM is combinational pass-through, 0-cycle latency:
  - w_valid_o = seq_valid_i; seq_ready_o = w_ready_i.
  - Out beat k bytes [off..BusBytes-1] = input beat k bytes [0..BusBytes-off-1].
  - Out beat k bytes [0..off-1] = residue (input beat k-1 bytes [BusBytes-off..BusBytes-1]).
  - For k=0, the residue portion has strobe 0.
- Strobe clipping: stream position p = k*BusBytes + j - off. w_strb_o[j] forced 0 when p<0 or p>=nbytes. Data in clipped bytes is don't-care; the bench must not check it.
- On each seq handshake: residue <= upper off bytes of the input data and strobes, and in_cnt increments.
- w_last_o=1 on out beat out_beats-1.
- STREAM exit on the handshake of input beat in_beats-1:
  - If out_beats>in_beats, go to FLUSH.
  - Otherwise this beat carries w_last_o; go to IDLE and pulse done_o next cycle.
- FLUSH:
  - seq_ready_o=0; w_valid_o=1.
  - Data and strobes come from the residue only, at bytes [0..off-1], clipped as above.
  - w_last_o=1.
  - On w handshake: go to IDLE, done_o pulses next cycle.
- Backpressure: while w_ready_i=0, no input is consumed and the residue is unchanged. Outputs stay stable while w_valid_o=1 and seq inputs are held (AXI valid/ready rule).
- seq beats offered in IDLE or FLUSH are not accepted (seq_ready_o=0).
- Throughput: one W beat per cycle in STREAM. One bubble-free FLUSH beat. Next request accepted the cycle after done_o.
- Assertions:
  - seq_valid_i never drops without a handshake.
  - w_strb_o never set outside [off, off+nbytes) of the request.

Test Plan (NrLanes=4, DLEN=64, BusBytes=32):
- Aligned: off=0, nbytes=64, two beats, all en=1 → 2 W beats, strb=0xFFFFFFFF each, w_last on beat 2, done_o one cycle later.
- Misaligned: off=4, nbytes=32, input bytes 0x00..0x1F → beat0 strb=0xFFFFFFF0 with data bytes[4..31]=0x00..0x1B; FLUSH beat strb=0x0000000F with bytes[0..3]=0x1C..0x1F, w_last=1.
- Tail clip: off=0, nbytes=40 → beat1 strb=0x000000FF, w_last=1, no FLUSH.
- Masking: off=0, nbytes=32, seq_en_i=0x0F0F…0F (nibbles 0-3 set per 8) → strb=0x33333333.
- Backpressure: misaligned case with w_ready_i=0 for 3 cycles mid-stream → seq_ready_o=0 and w_data_o/w_strb_o held for those cycles; final beats identical to the unstalled run.
- Edge cases:
  - nbytes=0 → no W beats, done_o pulses next cycle.
  - Assert rst_ni during STREAM → all outputs 0 immediately, req_ready_o=1 after release.

Source files
------------

// File: rtl/seq_store_aligner_if.sv
// ---------------------------------------------------------------------------
// seq_store_aligner_if
// Bundles the three handshakes around the store aligner:
//   req_*  : request from the store control path (byte offset, byte count)
//   seq_*  : sequential nibble-enabled store beats from the lane deshuffle
//   w_*    : AXI-style W beats toward memory, plus the done_o pulse
// slave  : the aligner's view (consumes req/seq, produces W/done)
// master : the driving side (control path / deshuffle / W sink)
// ---------------------------------------------------------------------------
interface seq_store_aligner_if #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned DLEN    = 64,
   parameter int unsigned LenBits = 16
);
   localparam int unsigned BusBits  = NrLanes * DLEN;
   localparam int unsigned BusBytes = BusBits / 8;
   localparam int unsigned OffBits  = $clog2(BusBytes);

   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [OffBits-1:0]   req_off_i;
   logic [LenBits-1:0]   req_nbytes_i;

   logic                 seq_valid_i;
   logic                 seq_ready_o;
   logic [BusBits-1:0]   seq_nb_i;
   logic [BusBits/4-1:0] seq_en_i;

   logic                 w_valid_o;
   logic                 w_ready_i;
   logic [BusBits-1:0]   w_data_o;
   logic [BusBytes-1:0]  w_strb_o;
   logic                 w_last_o;
   logic                 done_o;

   modport slave (
      input  req_valid_i, req_off_i, req_nbytes_i,
      input  seq_valid_i, seq_nb_i, seq_en_i,
      input  w_ready_i,
      output req_ready_o, seq_ready_o,
      output w_valid_o, w_data_o, w_strb_o, w_last_o, done_o
   );

   modport master (
      output req_valid_i, req_off_i, req_nbytes_i,
      output seq_valid_i, seq_nb_i, seq_en_i,
      output w_ready_i,
      input  req_ready_o, seq_ready_o,
      input  w_valid_o, w_data_o, w_strb_o, w_last_o, done_o
   );
endinterface

// File: rtl/seq_store_aligner.sv
// ---------------------------------------------------------------------------
// seq_store_aligner
// Takes sequential store beats (stream byte 0 at bus byte 0), shifts them to
// the destination byte offset of the request, turns nibble enables into byte
// strobes and emits W beats with a last flag. One request at a time.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : seq_store_aligner_if.slave (req_*, seq_*, w_*, done_o)
// STREAM is a zero-latency pass-through; the bytes that spill past the end of
// each bus word are kept as a residue and prepended to the next output beat.
// A trailing FLUSH beat drains the residue when the shifted request needs one
// more bus word than the input stream provides.
// ---------------------------------------------------------------------------
module seq_store_aligner #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned DLEN    = 64,
   parameter int unsigned LenBits = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   seq_store_aligner_if.slave bus
);
   localparam int unsigned BusBits  = NrLanes * DLEN;
   localparam int unsigned BusBytes = BusBits / 8;
   localparam int unsigned OffBits  = $clog2(BusBytes);
   localparam int unsigned CntW     = LenBits - OffBits + 1;
   localparam int unsigned PosW     = CntW + OffBits;
   localparam int unsigned SumW     = LenBits + 2;
   localparam int unsigned ShW      = OffBits + 4;
   localparam int unsigned SbW      = OffBits + 1;

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

   state_e              state_q, state_d;
   logic                done_q, done_d;
   logic [OffBits-1:0]  off_q;
   logic [LenBits-1:0]  nbytes_q;
   logic [CntW-1:0]     in_beats_q, out_beats_q, in_cnt_q;
   logic [BusBits-1:0]  res_data_q;
   logic [BusBytes-1:0] res_strb_q;

   logic                req_acc, seq_hs;
   logic [BusBytes-1:0] s_in, win;
   logic [SumW-1:0]     in_sum, out_sum;
   logic [ShW-1:0]      sh_lo, sh_hi;
   logic [SbW-1:0]      sb_hi;

   function automatic logic [BusBytes-1:0] nib2strb(input logic [BusBits/4-1:0] en);
      logic [BusBytes-1:0] s;
      for (int i = 0; i < BusBytes; i++) s[i] = en[2*i] | en[2*i+1];
      return s;
   endfunction

   // Bytes of out beat k whose absolute position lies in [off, off+nbytes).
   function automatic logic [BusBytes-1:0] win_mask(input logic [CntW-1:0]    k,
                                                    input logic [OffBits-1:0] off,
                                                    input logic [LenBits-1:0] nb);
      logic [BusBytes-1:0] m;
      logic [PosW-1:0]     pos, lo, hi;
      lo = PosW'(off);
      hi = PosW'(off) + PosW'(nb);
      for (int j = 0; j < BusBytes; j++) begin
         pos  = {k, OffBits'(j)};
         m[j] = (pos >= lo) && (pos < hi);
      end
      return m;
   endfunction

   assign s_in    = nib2strb(bus.seq_en_i);
   assign win     = win_mask(in_cnt_q, off_q, nbytes_q);
   assign sh_lo   = ShW'(off_q) << 3;
   assign sh_hi   = ShW'(BusBits) - sh_lo;
   assign sb_hi   = SbW'(BusBytes) - SbW'(off_q);
   assign in_sum  = SumW'(bus.req_nbytes_i) + SumW'(BusBytes - 1);
   assign out_sum = in_sum + SumW'(bus.req_off_i);
   // A zero-length request offered while done_o is high is ignored.
   assign req_acc = bus.req_valid_i && !(done_q && bus.req_nbytes_i == '0);
   assign bus.done_o = done_q;

   always_comb begin
      state_d         = state_q;
      done_d          = 1'b0;
      seq_hs          = 1'b0;
      bus.req_ready_o = 1'b0;
      bus.seq_ready_o = 1'b0;
      bus.w_valid_o   = 1'b0;
      bus.w_data_o    = '0;
      bus.w_strb_o    = '0;
      bus.w_last_o    = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.req_ready_o = 1'b1;
            if (req_acc) begin
               if (bus.req_nbytes_i == '0) done_d  = 1'b1;
               else                        state_d = STREAM;
            end
         end
         STREAM: begin
            bus.w_valid_o   = bus.seq_valid_i;
            bus.seq_ready_o = bus.w_ready_i;
            bus.w_data_o    = (bus.seq_nb_i << sh_lo) | res_data_q;
            bus.w_strb_o    = ((s_in << off_q) | res_strb_q) & win;
            bus.w_last_o    = (in_cnt_q == out_beats_q - CntW'(1));
            seq_hs          = bus.seq_valid_i && bus.w_ready_i;
            if (seq_hs && in_cnt_q == in_beats_q - CntW'(1)) begin
               if (out_beats_q > in_beats_q) begin
                  state_d = FLUSH;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         FLUSH: begin
            bus.w_valid_o = 1'b1;
            bus.w_data_o  = res_data_q;
            bus.w_strb_o  = res_strb_q & win;
            bus.w_last_o  = 1'b1;
            if (bus.w_ready_i) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- request / residue registers ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         off_q       <= '0;
         nbytes_q    <= '0;
         in_beats_q  <= '0;
         out_beats_q <= '0;
         in_cnt_q    <= '0;
         res_data_q  <= '0;
         res_strb_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (state_q == IDLE) begin
            res_data_q <= '0;
            res_strb_q <= '0;
            in_cnt_q   <= '0;
            if (req_acc) begin
               off_q       <= bus.req_off_i;
               nbytes_q    <= bus.req_nbytes_i;
               in_beats_q  <= CntW'(in_sum >> OffBits);
               out_beats_q <= CntW'(out_sum >> OffBits);
            end
         end else if (seq_hs) begin
            res_data_q <= bus.seq_nb_i >> sh_hi;
            res_strb_q <= s_in >> sb_hi;
            in_cnt_q   <= in_cnt_q + CntW'(1);
         end
      end
   end

   a_seq_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == STREAM && bus.seq_valid_i && !bus.seq_ready_o) |=> bus.seq_valid_i);

   a_strb_win: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.w_strb_o & ~win) == '0);
endmodule

// File: tb/tb_seq_store_aligner.sv
// ---------------------------------------------------------------------------
// tb_seq_store_aligner
// Directed bench for seq_store_aligner (NrLanes=4, DLEN=64, 32-byte bus).
// Input beat b carries stream bytes b*32+i at bus byte i, so the expected
// content of output byte j of beat k is simply k*32 + j - off.
// ---------------------------------------------------------------------------
module tb_seq_store_aligner;
   localparam int NrLanes = 4;
   localparam int DLEN    = 64;
   localparam int LenBits = 16;
   localparam logic [63:0] AllEn = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   seq_store_aligner_if #(.NrLanes(NrLanes), .DLEN(DLEN), .LenBits(LenBits)) bus ();

   seq_store_aligner #(.NrLanes(NrLanes), .DLEN(DLEN), .LenBits(LenBits)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   function automatic logic [255:0] beat(input int b);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'(b*32 + i);
      return r;
   endfunction

   function automatic logic [255:0] expd(input int k, input int off);
      logic [255:0] r;
      for (int j = 0; j < 32; j++) r[j*8 +: 8] = 8'(k*32 + j - off);
      return r;
   endfunction

   function automatic logic [255:0] bmask(input logic [31:0] s);
      logic [255:0] m;
      for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{s[i]}};
      return m;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input string tag, input int k, input int off,
                             input logic [31:0] strb, input logic last);
      logic [255:0] m;
      m = bmask(strb);
      chk1  ({tag, ".valid"}, bus.w_valid_o, 1'b1);
      chk32 ({tag, ".strb"},  bus.w_strb_o, strb);
      chk256({tag, ".data"},  bus.w_data_o & m, expd(k, off) & m);
      chk1  ({tag, ".last"},  bus.w_last_o, last);
   endtask

   task automatic drive_seq(input logic v, input int b, input logic [63:0] en, input logic rdy);
      bus.seq_valid_i = v;
      bus.seq_nb_i    = beat(b);
      bus.seq_en_i    = en;
      bus.w_ready_i   = rdy;
   endtask

   task automatic request(input string tag, input int off, input int nb);
      bus.req_valid_i  = 1'b1;
      bus.req_off_i    = 5'(off);
      bus.req_nbytes_i = 16'(nb);
      #1;
      chk1({tag, ".req_ready"}, bus.req_ready_o, 1'b1);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
   endtask

   // Called one cycle after the final W handshake.
   task automatic check_done(input string tag);
      drive_seq(1'b0, 0, '0, 1'b1);
      #1;
      chk1({tag, ".done"},   bus.done_o, 1'b1);
      chk1({tag, ".wvalid"}, bus.w_valid_o, 1'b0);
      @(negedge clk);
      #1;
      chk1({tag, ".done_clr"},  bus.done_o, 1'b0);
      chk1({tag, ".req_ready"}, bus.req_ready_o, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_off_i    = '0;
      bus.req_nbytes_i = '0;
      drive_seq(1'b0, 0, '0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk1  ("rst.req_ready", bus.req_ready_o, 1'b1);
      chk1  ("rst.seq_ready", bus.seq_ready_o, 1'b0);
      chk1  ("rst.w_valid",   bus.w_valid_o, 1'b0);
      chk1  ("rst.w_last",    bus.w_last_o, 1'b0);
      chk1  ("rst.done",      bus.done_o, 1'b0);
      chk32 ("rst.strb",      bus.w_strb_o, 32'h0);
      chk256("rst.data",      bus.w_data_o, 256'h0);
      @(negedge clk);

      // Aligned, two full beats
      request("t1", 0, 64);
      drive_seq(1'b1, 0, AllEn, 1'b1);
      #1;
      chk1("t1.req_busy", bus.req_ready_o, 1'b0);
      chk1("t1.seq_ready", bus.seq_ready_o, 1'b1);
      check_beat("t1.b0", 0, 0, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      drive_seq(1'b1, 1, AllEn, 1'b1);
      #1;
      check_beat("t1.b1", 1, 0, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      check_done("t1");

      // Misaligned, one input beat plus a FLUSH beat
      request("t2", 4, 32);
      drive_seq(1'b1, 0, AllEn, 1'b1);
      #1;
      check_beat("t2.b0", 0, 4, 32'hFFFF_FFF0, 1'b0);
      @(negedge clk);
      drive_seq(1'b0, 0, '0, 1'b1);
      #1;
      chk1("t2.fl_seq_ready", bus.seq_ready_o, 1'b0);
      check_beat("t2.fl", 1, 4, 32'h0000_000F, 1'b1);
      @(negedge clk);
      check_done("t2");

      // Tail clip, no FLUSH
      request("t3", 0, 40);
      drive_seq(1'b1, 0, AllEn, 1'b1);
      #1;
      check_beat("t3.b0", 0, 0, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      drive_seq(1'b1, 1, AllEn, 1'b1);
      #1;
      check_beat("t3.b1", 1, 0, 32'h0000_00FF, 1'b1);
      @(negedge clk);
      check_done("t3");

      // Nibble-enable masking
      request("t4", 0, 32);
      drive_seq(1'b1, 0, {8{8'h0F}}, 1'b1);
      #1;
      check_beat("t4.b0", 0, 0, 32'h3333_3333, 1'b1);
      @(negedge clk);
      check_done("t4");

      // Backpressure mid-stream on a misaligned two-beat request
      request("t5", 4, 64);
      drive_seq(1'b1, 0, AllEn, 1'b1);
      #1;
      check_beat("t5.b0", 0, 4, 32'hFFFF_FFF0, 1'b0);
      @(negedge clk);
      drive_seq(1'b1, 1, AllEn, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("t5.stall_seq_ready", bus.seq_ready_o, 1'b0);
         check_beat("t5.stall", 1, 4, 32'hFFFF_FFFF, 1'b0);
         @(negedge clk);
      end
      bus.w_ready_i = 1'b1;
      #1;
      chk1("t5.seq_ready", bus.seq_ready_o, 1'b1);
      check_beat("t5.b1", 1, 4, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      drive_seq(1'b0, 0, '0, 1'b1);
      #1;
      check_beat("t5.fl", 2, 4, 32'h0000_000F, 1'b1);
      @(negedge clk);
      check_done("t5");

      // Zero-length request
      request("t6", 0, 0);
      #1;
      chk1("t6.done",      bus.done_o, 1'b1);
      chk1("t6.w_valid",   bus.w_valid_o, 1'b0);
      chk1("t6.req_ready", bus.req_ready_o, 1'b1);
      @(negedge clk);
      #1;
      chk1("t6.done_clr", bus.done_o, 1'b0);
      chk1("t6.w_valid2", bus.w_valid_o, 1'b0);
      @(negedge clk);

      // Reset during STREAM, then a clean request
      request("t7", 0, 64);
      drive_seq(1'b1, 0, AllEn, 1'b1);
      #1;
      check_beat("t7.b0", 0, 0, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      drive_seq(1'b1, 1, AllEn, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1  ("t7.rst_w_valid",   bus.w_valid_o, 1'b0);
      chk1  ("t7.rst_seq_ready", bus.seq_ready_o, 1'b0);
      chk1  ("t7.rst_w_last",    bus.w_last_o, 1'b0);
      chk1  ("t7.rst_done",      bus.done_o, 1'b0);
      chk32 ("t7.rst_strb",      bus.w_strb_o, 32'h0);
      chk256("t7.rst_data",      bus.w_data_o, 256'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_seq(1'b0, 0, '0, 1'b1);
      #1;
      chk1("t7.req_ready", bus.req_ready_o, 1'b1);
      chk1("t7.w_valid",   bus.w_valid_o, 1'b0);
      @(negedge clk);
      request("t8", 0, 32);
      drive_seq(1'b1, 0, AllEn, 1'b1);
      #1;
      check_beat("t8.b0", 0, 0, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      check_done("t8");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
